osa_input_skewer: RTL and testbench
===================================

// Module: osa_input_skewer
// PURPOSE
//   Upstream feeder for the N x N output-stationary systolic PE array. Accepts one column of A
//   (A[i][k], i=0..N-1) and one row of B (B[k][j], j=0..N-1) per beat over valid/ready, and drives
//   the array's left edge (row lanes) and top edge (column lanes) with skewed wavefronts so that
//   PE(i,j) sees A[i][k] and B[k][j] in the same cycle. Zeros fill every idle slot, because PEs
//   accumulate unconditionally. A done pulse marks the edge at which PE(N-1,N-1) has accumulated its final product.
// PARAMETERS
//   N             4   array dimension; number of row lanes and column lanes
//   IP_DATA_WIDTH 8   element width W
//   KW            8   width of k_len; max reduction length 2^KW-1
// PORTS
//   clk      in   1        clock, all state on rising edge
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        single-cycle job start; sampled only in IDLE
//   k_len    in   KW       reduction length K, sampled with start
//   in_valid in   1        beat valid
//   in_ready out  1        beat ready; beat accepted on edge with in_valid & in_ready
//   in_a     in   N*W      A column; lane i = in_a[i*W +: W]
//   in_b     in   N*W      B row;    lane j = in_b[j*W +: W]
//   row_out  out  N*W      to PE(i,0).in_data_0; lane i = row_out[i*W +: W]
//   col_out  out  N*W      to PE(0,j).in_data_1; lane j = col_out[j*W +: W]
//   busy     out  1        high in LOAD and DRAIN
//   done     out  1        one-cycle pulse, job complete
// BEHAVIOUR
//   Reset: state IDLE, all skew registers, counters, row_out, col_out, in_ready, busy, done = 0.
//   Skew: lane i (row and column alike) is a shift register of depth 1+i, registered output.
//   - Every edge all lanes shift together. Lane input = in_a/in_b lane on accepted beat, else 0.
//   - Beat accepted at edge e appears on lane i output in the cycle after edge e+i.
//   - With the array's 1-cycle hop per PE, PE(i,j) sees beat k in the cycle after edge e+i+j;
//     A and B operands align at every PE.
//   FSM states: IDLE, LOAD, DRAIN.
//   - IDLE: in_ready=0, busy=0. start & k_len!=0 -> LOAD, load beat counter with k_len.
//     start & k_len==0 -> stay IDLE, done=1 in the next cycle. start outside IDLE is ignored.
//   - LOAD: in_ready=1, busy=1. Each accepted beat decrements the beat counter. Cycles without
//     in_valid inject an all-zero bubble on every lane; alignment is preserved and the result is unchanged.
//     On acceptance of the K-th beat (edge eL) -> DRAIN, load drain counter with 2N-2.
//   - DRAIN: in_ready=0, busy=1, lanes shift zeros. Drain counter decrements each edge. At the
//     edge where the counter is 0 (edge eL+2N-1, the edge at which PE(N-1,N-1) accumulates beat K)
//     -> IDLE and register done=1. done is therefore high for exactly one cycle after that edge.
//   - start presented in the same cycle the FSM returns to IDLE is accepted on the following cycle only.
//   Output data are pure register outputs, with no combinational path from in_* to row_out/col_out.
//   The block does not clear PE accumulators. A new tile requires the array to be reset (rst_n)
//   or pre-cleared by the system. The feeder supports back-to-back jobs only in that context.
//   Reset mid-job: immediate return to IDLE, all lanes zero, and done is not asserted.
//   Width rules: no arithmetic on data, the feeder passes elements bit-exact. Counters are KW bits and
//   ceil(log2(2N-1)) bits.
// TESTING
//   1. Reset: assert rst_n low mid-cycle -> all outputs 0 asynchronously. in_ready=0, busy=0.
//   2. N=4, K=1, in_a={4,3,2,1}, in_b={8,7,6,5}, accepted at edge e -> row lane i = i+1 and
//      col lane j = j+5, each only in the cycle after edge e+i (resp. e+j), 0 otherwise. done after edge e+7.
//   3. N=4, K=4, A=B=identity-ramp, in_valid held high -> array result C=A*B exact in all 16 PEs at done.
//      The same job with in_valid toggling 1,0,1,0 gives an identical C, and done is delayed by the bubble count.
//   4. k_len=0 with start -> no LOAD, in_ready stays 0, done pulses once in the cycle after start.
//   5. start pulsed during LOAD and during DRAIN -> ignored, and beat count/done timing are unchanged.
//   6. rst_n asserted after 2 of 4 beats -> outputs 0, FSM IDLE, no done. A new start then runs normally.

Source files
------------

// File: rtl/osa_input_skewer_if.sv
// Beat bus into the systolic-array input skewer: one A column and one B row per accepted beat.
interface osa_input_skewer_if #(
    parameter int unsigned N             = 4,
    parameter int unsigned IP_DATA_WIDTH = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [N*IP_DATA_WIDTH-1:0] in_a;
    logic [N*IP_DATA_WIDTH-1:0] in_b;

    modport master (output in_valid, output in_a, output in_b, input in_ready);
    modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/osa_input_skewer.sv
// Input skewer for an N x N output-stationary systolic array: turns one A column / B row per
// beat into diagonal wavefronts on the row and column edges, zero-filling every idle slot.
module osa_input_skewer #(
    parameter int unsigned N             = 4,
    parameter int unsigned IP_DATA_WIDTH = 8,
    parameter int unsigned KW            = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [KW-1:0]              k_len,
    osa_input_skewer_if.slave          bus,
    output logic [N*IP_DATA_WIDTH-1:0] row_out,
    output logic [N*IP_DATA_WIDTH-1:0] col_out,
    output logic                       busy,
    output logic                       done
);
    localparam int unsigned W  = IP_DATA_WIDTH;
    localparam int unsigned DW = $clog2(2*N-1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(2*N-2);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            done_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_d;
    logic            accept;

    assign bus.in_ready = in_ready_q;
    assign accept       = bus.in_valid & in_ready_q;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        state_d    = LOAD;
                        beat_cnt_d = k_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q - KW'(1);
                    if (beat_cnt_q == KW'(1)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_INIT;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
    end

    // FSM state, counters and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            in_ready_q  <= in_ready_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Lane i is a (1+i)-deep shift register; the oldest slot drives the array edge.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0]         a_in;
        logic [W-1:0]         b_in;
        logic [(i+1)*W-1:0]   a_sh;
        logic [(i+1)*W-1:0]   b_sh;

        assign a_in = accept ? bus.in_a[i*W +: W] : '0;
        assign b_in = accept ? bus.in_b[i*W +: W] : '0;

        if (i == 0) begin : g_d1
            // Single-stage lane: capture the accepted element or a zero bubble.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_sh <= '0;
                    b_sh <= '0;
                end else begin
                    a_sh <= a_in;
                    b_sh <= b_in;
                end
            end
        end else begin : g_dn
            // Multi-stage lane: new element enters the low slot, older ones move up.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_sh <= '0;
                    b_sh <= '0;
                end else begin
                    a_sh <= {a_sh[i*W-1:0], a_in};
                    b_sh <= {b_sh[i*W-1:0], b_in};
                end
            end
        end

        assign row_out[i*W +: W] = a_sh[(i+1)*W-1 -: W];
        assign col_out[i*W +: W] = b_sh[(i+1)*W-1 -: W];
    end
endmodule

// File: tb/tb_osa_input_skewer.sv
// Bench for osa_input_skewer: job table plus a lane/done scoreboard and a 4x4 PE array model.
module tb_osa_input_skewer;
    localparam int unsigned N    = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned KW   = 8;
    localparam int unsigned MAXK = 16;

    typedef struct {
        int          k;
        logic [15:0] gap;       // bit b: one bubble cycle before beat b
        int          kind;      // 0: test-2 vector, 1: ramp, 2: random
        bit          st_load;   // stray start pulses during LOAD
        bit          st_drain;  // stray start pulse during DRAIN
        bit          st_end;    // start (k_len=0) in the final DRAIN cycle and the next
        int          lat;       // expected done cycle minus start-sample edge
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic [N*W-1:0]  row_out, col_out;
    logic            busy, done;

    osa_input_skewer_if #(.N(N), .IP_DATA_WIDTH(W)) bus();

    osa_input_skewer #(.N(N), .IP_DATA_WIDTH(W), .KW(KW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .k_len   (k_len),
        .bus     (bus.slave),
        .row_out (row_out),
        .col_out (col_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected lane words keyed by cycle, expected done cycles in order.
    logic [N*W-1:0] exp_row [int];
    logic [N*W-1:0] exp_col [int];
    int             done_q [$];

    logic [N*W-1:0] er, ec;
    logic           ed;
    always @(negedge clk) begin
        er = exp_row.exists(cyc) ? exp_row[cyc] : '0;
        ec = exp_col.exists(cyc) ? exp_col[cyc] : '0;
        if (exp_row.exists(cyc)) exp_row.delete(cyc);
        if (exp_col.exists(cyc)) exp_col.delete(cyc);
        ed = (done_q.size() > 0) && (done_q[0] == cyc);
        if (ed) void'(done_q.pop_front());
        check("row_out", 64'(row_out), 64'(er));
        check("col_out", 64'(col_out), 64'(ec));
        check("done", 64'(done), 64'(ed));
    end

    // Output-stationary PE array model fed from the skewer edges, one hop per PE.
    int           acc [N][N];
    logic [W-1:0] ar  [N][N];
    logic [W-1:0] br  [N][N];
    bit           pe_clr = 1'b0;

    function automatic logic [W-1:0] pe_a(input int i, input int j);
        return (j == 0) ? row_out[i*W +: W] : ar[i][(j > 0) ? j-1 : 0];
    endfunction
    function automatic logic [W-1:0] pe_b(input int i, input int j);
        return (i == 0) ? col_out[j*W +: W] : br[(i > 0) ? i-1 : 0][j];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!rst_n || pe_clr) begin
                    acc[i][j] <= 0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + int'(pe_a(i, j)) * int'(pe_b(i, j));
                    ar[i][j]  <= pe_a(i, j);
                    br[i][j]  <= pe_b(i, j);
                end
            end
        end
    end

    task automatic push_beat(input int e, input logic [N*W-1:0] va, input logic [N*W-1:0] vb);
        logic [N*W-1:0] tmp;
        for (int i = 0; i < N; i++) begin
            tmp = exp_row.exists(e+i) ? exp_row[e+i] : '0;
            tmp[i*W +: W] = va[i*W +: W];
            exp_row[e+i] = tmp;
            tmp = exp_col.exists(e+i) ? exp_col[e+i] : '0;
            tmp[i*W +: W] = vb[i*W +: W];
            exp_col[e+i] = tmp;
        end
    endtask

    task automatic run_job(input vec_t v);
        logic [W-1:0]   opa [N][MAXK];
        logic [W-1:0]   opb [MAXK][N];
        logic [N*W-1:0] va, vb;
        int             s, c_exp;
        for (int k = 0; k < v.k; k++) begin
            for (int i = 0; i < N; i++) begin
                case (v.kind)
                    0:       begin opa[i][k] = W'(i+1);     opb[k][i] = W'(i+5); end
                    1:       begin opa[i][k] = W'(i+k+1);   opb[k][i] = W'(k*N+i+1); end
                    default: begin opa[i][k] = W'($urandom); opb[k][i] = W'($urandom); end
                endcase
            end
        end
        @(negedge clk);
        start = 1'b1; k_len = KW'(v.k); pe_clr = 1'b1;
        bus.in_valid = 1'b1; bus.in_a = (N*W)'($urandom); bus.in_b = (N*W)'($urandom);
        s = cyc + 1;
        done_q.push_back(s + v.lat);
        @(negedge clk);
        start = 1'b0; pe_clr = 1'b0;
        check("busy_after_start", 64'(busy), 64'(v.k != 0));
        check("ready_after_start", 64'(bus.in_ready), 64'(v.k != 0));
        for (int k = 0; k < v.k; k++) begin
            if (v.gap[k]) begin
                bus.in_valid = 1'b0; bus.in_a = (N*W)'($urandom); bus.in_b = (N*W)'($urandom);
                if (v.st_load) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                va[i*W +: W] = opa[i][k];
                vb[i*W +: W] = opb[k][i];
            end
            bus.in_valid = 1'b1; bus.in_a = va; bus.in_b = vb;
            push_beat(cyc + 1, va, vb);
            if (v.st_load && k == 1) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        bus.in_a = (N*W)'($urandom); bus.in_b = (N*W)'($urandom);
        if (v.k != 0) begin
            check("ready_in_drain", 64'(bus.in_ready), 64'(0));
            check("busy_in_drain", 64'(busy), 64'(1));
            if (v.st_drain) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (cyc < s + v.lat) begin
            if (v.st_end && cyc == s + v.lat - 1) begin
                start = 1'b1; k_len = '0;
                done_q.push_back(s + v.lat + 1);
            end
            @(negedge clk);
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c_exp = 0;
                for (int k = 0; k < v.k; k++) c_exp += int'(opa[i][k]) * int'(opb[k][j]);
                check($sformatf("C[%0d][%0d] k=%0d", i, j, v.k), 64'(acc[i][j]), 64'(c_exp));
            end
        end
        check("busy_at_done", 64'(busy), 64'(0));
        check("ready_at_done", 64'(bus.in_ready), 64'(0));
        if (v.st_end) begin
            @(negedge clk);
            start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    vec_t tv [7];

    initial begin
        tv[0] = '{k:1, gap:16'h0000, kind:0, st_load:0, st_drain:0, st_end:0, lat:8};
        tv[1] = '{k:4, gap:16'h0000, kind:1, st_load:0, st_drain:0, st_end:0, lat:11};
        tv[2] = '{k:4, gap:16'h000E, kind:1, st_load:0, st_drain:0, st_end:0, lat:14};
        tv[3] = '{k:0, gap:16'h0000, kind:1, st_load:0, st_drain:0, st_end:0, lat:0};
        tv[4] = '{k:4, gap:16'h0000, kind:2, st_load:1, st_drain:1, st_end:0, lat:11};
        tv[5] = '{k:3, gap:16'h0005, kind:2, st_load:0, st_drain:0, st_end:0, lat:12};
        tv[6] = '{k:9, gap:16'h0008, kind:2, st_load:1, st_drain:0, st_end:1, lat:17};

        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        #3;
        check("reset_row", 64'(row_out), 64'(0));
        check("reset_col", 64'(col_out), 64'(0));
        check("reset_ready", 64'(bus.in_ready), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 7; t++) run_job(tv[t]);

        // Reset after 2 of 4 beats: everything returns to zero and no done follows.
        @(negedge clk);
        start = 1'b1; k_len = KW'(4);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.in_a = (N*W)'($urandom) | (N*W)'(1);
            bus.in_b = (N*W)'($urandom) | (N*W)'(1);
            push_beat(cyc + 1, bus.in_a, bus.in_b);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #2;
        check("pre_reset_row_nonzero", 64'(row_out != '0), 64'(1));
        rst_n = 1'b0;
        exp_row.delete(); exp_col.delete(); done_q.delete();
        #1;
        check("async_reset_row", 64'(row_out), 64'(0));
        check("async_reset_col", 64'(col_out), 64'(0));
        check("async_reset_ready", 64'(bus.in_ready), 64'(0));
        check("async_reset_busy", 64'(busy), 64'(0));
        check("async_reset_done", 64'(done), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("idle_after_reset_busy", 64'(busy), 64'(0));

        run_job(tv[1]);
        run_job(tv[3]);
        run_job(tv[2]);
        repeat (3) @(negedge clk);

        check("done_queue_drained", 64'(done_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
